uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds per-frame selectable data length, parity (none/even/odd) and 1 or 2 stop bits, plus a one-entry holding buffer so frames go out back-to-back with no idle gap. Sits between a host/command engine and the serial TX pin. Uses a single clock domain.

Parameters:
BAUD_DIV, 2604, clocks per bit period (≥4); counter width is $clog2(BAUD_DIV).
DATA_BITS, 8, data bits per frame (5..9), sent LSB first.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
trmt  input  1  request to send; accepted when tx_rdy=1
tx_data  input  DATA_BITS  frame payload, sampled on acceptance
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; sampled on acceptance
two_stop  input  1  1 = two stop bits; sampled on acceptance
TX  output  1  serial line, registered, idles high
tx_rdy  output  1  low only while holding buffer is full
busy  output  1  high while a frame is on the line
tx_done  output  1  sticky frame-complete flag

Behaviour:
- Single clock clk; reset is synchronous and active-high on rst. It is sampled only on the clk rising edge.
- Reset values: TX=1, tx_rdy=1, busy=0, tx_done=0, state=IDLE, holding buffer empty, counters 0. A reset mid-frame aborts the frame and TX returns high on the next edge.
- Acceptance: trmt && tx_rdy on an edge captures {tx_data, parity_mode, two_stop}.
  - In IDLE, the captured word goes straight into the shift register.
  - When busy, it goes into the holding buffer. tx_rdy drops the next cycle.
  - trmt while tx_rdy=0 is ignored.
- Frame on TX: start bit (0), then DATA_BITS data bits LSB first, then an optional parity bit, then 1 or 2 stop bits (1).
  - Even parity bit = ^data. Odd parity bit = ~^data.
- Each bit is held for exactly BAUD_DIV clocks. The baud counter resets at the start of every bit.
- Latency: acceptance in IDLE at edge N gives TX=0 and busy=1 from edge N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE→START on accept.
  - START→DATA after BAUD_DIV clocks.
  - DATA→PARITY, or DATA→STOP when parity is none, after DATA_BITS bit periods.
  - PARITY→STOP after one period.
  - STOP ends after 1 or 2 periods. It then goes to START if the buffer is full, otherwise to IDLE.
- Back-to-back: the buffered frame's start bit begins on the edge right after the last stop period ends, with no idle gap. The buffer empties and tx_rdy=1 on that same edge.
  - A new trmt in that same cycle is accepted into the buffer; buffer load wins over buffer empty ordering.
- tx_done goes to 1 when a frame completes with the buffer empty (the STOP→IDLE edge), together with busy=0. It clears on the edge that accepts the next trmt.
- busy stays 1 continuously across back-to-back frames.
- Frame config is latched per frame. Changing parity_mode or two_stop mid-frame has no effect on the current frame.
- Frame length in clocks = BAUD_DIV × (1 + DATA_BITS + P + S), where P∈{0,1} and S∈{1,2}.

Decomposition:
- Package uart_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD).
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - frame_cfg_t struct (data, parity, two_stop), used for both the shift and holding registers.
- One sub-module, uart_baud_cnt:
  - Parameter BAUD_DIV.
  - Inputs clr and en.
  - Output bit_end, a one-cycle pulse at count BAUD_DIV-1.

Test Plan:
- BAUD_DIV=16, DATA_BITS=8, parity none, one stop; send 0xA5 → TX low 16 clks, then 1,0,1,0,0,1,0,1 at 16 clks each, then high. tx_done=1 and busy=0 exactly 160 clks after the TX falling edge.
- Even parity with 0x07, then odd parity with 0x07 → parity bit 1 then 0. Frame = 176 clks each.
- two_stop=1, DATA_BITS=5, send 0x1F → stop high 32 clks. Frame = 128 clks, data bits 1,1,1,1,1.
- Send 0x55 then 0x33 while busy → tx_rdy low after the 2nd accept. Second start bit begins on the clk right after the first stop ends. busy never drops; tx_done stays 0 until the end of the 2nd frame.
- Third trmt while tx_rdy=0 → ignored; only 2 frames appear on TX.
- Assert rst mid-DATA of a frame → next edge TX=1, busy=0, tx_rdy=1, tx_done=0. A subsequent send of 0x3C is transmitted correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the configurable UART transmitter
package uart_pkg;
    localparam int MAX_DATA_BITS = 9;
    typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_EVEN = 2'b01, PAR_ODD = 2'b10} parity_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        parity_t                  parity;
        logic                     two_stop;
    } frame_cfg_t;
    function automatic parity_t to_parity(input logic [1:0] mode);
        return (mode == 2'b01) ? PAR_EVEN : (mode == 2'b10) ? PAR_ODD : PAR_NONE;
    endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter pulsing bit_end on the last clock of each bit
module uart_baud_cnt #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);
    localparam int W = $clog2(BAUD_DIV);
    logic [W-1:0] cnt;
    assign bit_end = en && !clr && cnt == W'(BAUD_DIV - 1);
    always_ff @(posedge clk) begin
        if (rst || clr || bit_end) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with per-frame length/parity/stop config and one-entry holding buffer
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = 2604,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 TX,
    output logic                 tx_rdy,
    output logic                 busy,
    output logic                 tx_done
);
    localparam int IW = $clog2(DATA_BITS);
    tx_state_t            state;
    frame_cfg_t           cur, hold, in_cfg;
    logic [DATA_BITS-2:0] sh;
    logic [IW-1:0]        bit_idx;
    logic                 stop2, hold_full, bit_end, acc, par_bit, frame_end;
    assign in_cfg    = '{data: MAX_DATA_BITS'(tx_data), parity: to_parity(parity_mode), two_stop: two_stop};
    assign tx_rdy    = !hold_full;
    assign acc       = trmt && tx_rdy;
    assign par_bit   = ^cur.data ^ (cur.parity == PAR_ODD);
    assign frame_end = state == STOP && bit_end && (!cur.two_stop || stop2);
    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      (busy),
        .bit_end (bit_end)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            TX        <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            hold_full <= 1'b0;
            bit_idx   <= '0;
            stop2     <= 1'b0;
            sh        <= '0;
            cur       <= '0;
            hold      <= '0;
        end else begin
            if (acc) tx_done <= 1'b0;
            if (acc && state != IDLE && !frame_end) begin
                hold      <= in_cfg;
                hold_full <= 1'b1;
            end
            case (state)
                IDLE: if (acc) begin
                    cur   <= in_cfg;
                    state <= START;
                    TX    <= 1'b0;
                    busy  <= 1'b1;
                end
                START: if (bit_end) begin
                    state   <= DATA;
                    TX      <= cur.data[0];
                    sh      <= cur.data[DATA_BITS-1:1];
                    bit_idx <= '0;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == IW'(DATA_BITS - 1)) begin
                        state <= (cur.parity == PAR_NONE) ? STOP : PARITY;
                        TX    <= (cur.parity == PAR_NONE) ? 1'b1 : par_bit;
                        stop2 <= 1'b0;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                        TX      <= sh[0];
                        sh      <= sh >> 1;
                    end
                end
                PARITY: if (bit_end) begin
                    state <= STOP;
                    TX    <= 1'b1;
                    stop2 <= 1'b0;
                end
                STOP: if (bit_end) begin
                    if (!frame_end) stop2 <= 1'b1;
                    else if (hold_full || acc) begin
                        cur       <= hold_full ? hold : in_cfg;
                        hold_full <= 1'b0;
                        state     <= START;
                        TX        <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench decoding TX frames against hand-computed bit sequences
module tb_uart_tx_cfg;
    localparam int BD = 16;
    logic clk = 1'b0, rst = 1'b1, trmt = 1'b0, sel = 1'b0, mon_en = 1'b1;
    logic [7:0] tx_data = '0;
    logic [1:0] parity_mode = '0;
    logic two_stop = 1'b0;
    logic tx8, rdy8, busy8, done8, tx5, rdy5, busy5, done5;
    logic m_tx, m_rdy, m_busy, m_done;
    int checks = 0, errors = 0;
    string q_bits[$];
    logic q_last[$];
    always #5 clk = ~clk;
    uart_tx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .trmt(trmt && !sel), .tx_data(tx_data), .parity_mode(parity_mode),
        .two_stop(two_stop), .TX(tx8), .tx_rdy(rdy8), .busy(busy8), .tx_done(done8)
    );
    uart_tx_cfg #(.BAUD_DIV(BD), .DATA_BITS(5)) dut5 (
        .clk(clk), .rst(rst), .trmt(trmt && sel), .tx_data(tx_data[4:0]), .parity_mode(parity_mode),
        .two_stop(two_stop), .TX(tx5), .tx_rdy(rdy5), .busy(busy5), .tx_done(done5)
    );
    assign m_tx   = sel ? tx5 : tx8;
    assign m_rdy  = sel ? rdy5 : rdy8;
    assign m_busy = sel ? busy5 : busy8;
    assign m_done = sel ? done5 : done8;
    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %b expected %b at %0t", name, idx, act, exp, $time);
        end
    endtask
    task automatic frame_check();
        string b;
        logic last;
        if (q_bits.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: start bit seen with no frame expected at %0t", $time);
            while (m_tx === 1'b0) @(negedge clk);
            return;
        end
        b = q_bits.pop_front();
        last = q_last.pop_front();
        repeat (BD / 2) @(negedge clk);
        for (int i = 0; i < b.len(); i++) begin
            if (i > 0) repeat (BD) @(negedge clk);
            chk("frame_bit", i, m_tx, b.getc(i) == 8'h31);
        end
        repeat (BD / 2 - 1) @(negedge clk);
        chk("busy_at_last_clk", 0, m_busy, 1'b1);
        chk("done_at_last_clk", 0, m_done, 1'b0);
        @(negedge clk);
        if (last) begin
            chk("end_tx_idle", 0, m_tx, 1'b1);
            chk("end_busy", 0, m_busy, 1'b0);
            chk("end_done", 0, m_done, 1'b1);
            chk("end_rdy", 0, m_rdy, 1'b1);
        end else begin
            chk("b2b_start", 0, m_tx, 1'b0);
            chk("b2b_busy", 0, m_busy, 1'b1);
            chk("b2b_done", 0, m_done, 1'b0);
            chk("b2b_rdy", 0, m_rdy, 1'b1);
        end
    endtask
    initial begin
        forever begin
            @(negedge clk);
            while (mon_en && m_tx === 1'b0) frame_check();
        end
    end
    task automatic pulse(input logic [7:0] d, input logic [1:0] pm, input logic ts);
        tx_data = d;
        parity_mode = pm;
        two_stop = ts;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
        tx_data = 8'hFF;
        parity_mode = 2'b10;
        two_stop = ~ts;
    endtask
    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic ts, input string bits, input logic last);
        int n = 0;
        @(negedge clk);
        while (!m_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_timeout", 0, m_rdy, 1'b1);
        q_bits.push_back(bits);
        q_last.push_back(last);
        pulse(d, pm, ts);
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((q_bits.size() != 0 || m_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 0, m_busy, 1'b0);
        repeat (4) @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx8", 0, tx8, 1'b1);
        chk("rst_rdy8", 0, rdy8, 1'b1);
        chk("rst_busy8", 0, busy8, 1'b0);
        chk("rst_done8", 0, done8, 1'b0);
        chk("rst_tx5", 0, tx5, 1'b1);
        chk("rst_rdy5", 0, rdy5, 1'b1);
        chk("rst_busy5", 0, busy5, 1'b0);
        chk("rst_done5", 0, done5, 1'b0);
        send(8'hA5, 2'b00, 1'b0, "0101001011", 1'b1);
        wait_idle();
        send(8'h07, 2'b01, 1'b0, "01110000011", 1'b1);
        wait_idle();
        send(8'h07, 2'b10, 1'b0, "01110000001", 1'b1);
        wait_idle();
        sel = 1'b1;
        send(8'h1F, 2'b11, 1'b1, "01111111", 1'b1);
        wait_idle();
        sel = 1'b0;
        send(8'h55, 2'b00, 1'b0, "0101010101", 1'b0);
        send(8'h33, 2'b00, 1'b0, "0110011001", 1'b1);
        @(negedge clk);
        chk("rdy_low_after_buffer", 0, m_rdy, 1'b0);
        pulse(8'h0F, 2'b00, 1'b0);
        @(negedge clk);
        chk("rdy_low_after_ignored", 0, m_rdy, 1'b0);
        wait_idle();
        repeat (12 * BD) @(negedge clk);
        chk("no_third_frame_tx", 0, m_tx, 1'b1);
        chk("no_third_frame_busy", 0, m_busy, 1'b0);
        mon_en = 1'b0;
        @(negedge clk);
        pulse(8'h96, 2'b01, 1'b0);
        repeat (BD + 3 * BD) @(negedge clk);
        chk("pre_rst_busy", 0, m_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 0, m_tx, 1'b1);
        chk("midrst_busy", 0, m_busy, 1'b0);
        chk("midrst_rdy", 0, m_rdy, 1'b1);
        chk("midrst_done", 0, m_done, 1'b0);
        mon_en = 1'b1;
        send(8'h3C, 2'b00, 1'b0, "0001111001", 1'b1);
        wait_idle();
        chk("queue_drained", 0, q_bits.size() == 0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
